// File: rtl/sam_core.sv
// Simple accumulator machine: one-address instruction set, single shared memory port
// with a req/wait handshake, seven-state control sequencer.
module sam_core #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 12,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    output logic          mem_rw,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_wait,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ac,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_MEM,
        S_MEM_WAIT,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_JMP   = 3'b101,
        OP_JNEG  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] mar_q, mar_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] mbr_q, mbr_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_rw_q, mem_rw_d;

    opcode_e       opcode;
    logic [AW-1:0] operand;
    logic          xfer_done;
    logic          unused_ir_bits;

    assign opcode    = opcode_e'(ir_q[DW-1 -: 3]);
    assign operand   = ir_q[AW-1:0];
    assign xfer_done = mem_req_q && !mem_wait;
    // IR bits between opcode and operand carry no meaning.
    assign unused_ir_bits = ^ir_q[DW-4:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mar_d     = mar_q;
        ac_d      = ac_q;
        mbr_d     = mbr_q;
        ir_d      = ir_q;
        mem_req_d = mem_req_q;
        mem_rw_d  = mem_rw_q;

        case (state_q)
            S_FETCH: begin
                mar_d     = pc_q;
                mem_rw_d  = 1'b1;
                mem_req_d = 1'b1;
                state_d   = S_FETCH_WAIT;
            end

            S_FETCH_WAIT: begin
                if (xfer_done) begin
                    ir_d      = mem_rdata;
                    pc_d      = pc_q + AW'(PC_STEP);
                    mem_req_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_JMP: begin
                        pc_d    = operand;
                        state_d = S_FETCH;
                    end
                    OP_JNEG: begin
                        if (ac_q[DW-1]) begin
                            pc_d = operand;
                        end
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    OP_STORE: begin
                        mbr_d   = ac_q;
                        state_d = S_MEM;
                    end
                    default: begin
                        state_d = S_MEM;
                    end
                endcase
            end

            S_MEM: begin
                mar_d     = operand;
                mem_rw_d  = (opcode != OP_STORE);
                mem_req_d = 1'b1;
                state_d   = S_MEM_WAIT;
            end

            S_MEM_WAIT: begin
                if (xfer_done) begin
                    if (mem_rw_q) begin
                        mbr_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = (opcode == OP_STORE) ? S_FETCH : S_EXEC;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_LOAD: ac_d = mbr_q;
                    OP_ADD:  ac_d = ac_q + mbr_q;
                    OP_SUB:  ac_d = ac_q - mbr_q;
                    OP_AND:  ac_d = ac_q & mbr_q;
                    default: ac_d = ac_q;
                endcase
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= AW'(RESET_PC);
            mar_q     <= '0;
            ac_q      <= '0;
            mbr_q     <= '0;
            ir_q      <= '0;
            mem_req_q <= 1'b0;
            mem_rw_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            ac_q      <= ac_d;
            mbr_q     <= mbr_d;
            ir_q      <= ir_d;
            mem_req_q <= mem_req_d;
            mem_rw_q  <= mem_rw_d;
        end
    end

    assign mem_addr  = mar_q;
    assign mem_req   = mem_req_q;
    assign mem_rw    = mem_rw_q;
    assign mem_wdata = mbr_q;
    assign pc        = pc_q;
    assign ac        = ac_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_sam_core.sv
// Directed bench for sam_core: a 16-bit instance with a wait-state memory model and
// an 8-bit/5-bit instance that exercises PC wrap-around.
module tb_sam_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- 16-bit instance ----------------
    logic        rst0_n = 1'b1;
    logic [11:0] addr0, pc0;
    logic        req0, rw0, halted0, wait0;
    logic [15:0] wdata0, rdata0, ac0;
    logic [15:0] mem0 [0:4095];

    int   nwait = 0;
    logic wovr = 1'b0;
    logic wovr_val = 1'b0;
    int   wcnt = 0;
    int   stalls = 0;
    int   wr_count = 0;
    logic [11:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    assign rdata0 = mem0[addr0];
    assign wait0  = wovr ? wovr_val : (req0 && (wcnt < nwait));

    always @(posedge clk) begin
        if (req0) begin
            if (wait0) begin
                wcnt   <= wcnt + 1;
                stalls <= stalls + 1;
            end else begin
                wcnt <= 0;
                if (!rw0) begin
                    wr_count <= wr_count + 1;
                    wr_addr  <= addr0;
                    wr_data  <= wdata0;
                end
            end
        end else begin
            wcnt <= 0;
        end
    end

    int          rise_n = 0;
    int          rise_cyc [0:127];
    logic [11:0] rise_addr [0:127];
    logic        rise_rw [0:127];
    logic        req0_prev = 1'b0;
    logic [11:0] snap_addr = '0;
    logic        snap_rw = 1'b0;
    logic [15:0] snap_wdata = '0;
    int          viol = 0;

    always @(negedge clk) begin
        if (req0 && !req0_prev) begin
            rise_cyc[rise_n]  <= cyc;
            rise_addr[rise_n] <= addr0;
            rise_rw[rise_n]   <= rw0;
            rise_n            <= rise_n + 1;
            snap_addr         <= addr0;
            snap_rw           <= rw0;
            snap_wdata        <= wdata0;
        end else if (req0 && req0_prev) begin
            if (addr0 !== snap_addr || rw0 !== snap_rw || wdata0 !== snap_wdata)
                viol <= viol + 1;
        end
        req0_prev <= req0;
    end

    sam_core #(.DW(16), .AW(12), .PC_STEP(2), .RESET_PC(0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst0_n),
        .mem_addr (addr0),
        .mem_req  (req0),
        .mem_rw   (rw0),
        .mem_wdata(wdata0),
        .mem_rdata(rdata0),
        .mem_wait (wait0),
        .pc       (pc0),
        .ac       (ac0),
        .halted   (halted0)
    );

    // ---------------- 8-bit instance, reset PC near the top of the space ----------------
    logic       rst1_n = 1'b1;
    logic [4:0] addr1, pc1;
    logic       req1, rw1, halted1;
    logic       wait1 = 1'b0;
    logic [7:0] wdata1, rdata1, ac1;
    logic [7:0] mem1 [0:31];

    assign rdata1 = mem1[addr1];

    int         rise1_n = 0;
    int         rise1_cyc [0:31];
    logic [4:0] rise1_addr [0:31];
    logic       req1_prev = 1'b0;

    always @(negedge clk) begin
        if (req1 && !req1_prev && rise1_n < 32) begin
            rise1_cyc[rise1_n]  <= cyc;
            rise1_addr[rise1_n] <= addr1;
            rise1_n             <= rise1_n + 1;
        end
        req1_prev <= req1;
    end

    sam_core #(.DW(8), .AW(5), .PC_STEP(1), .RESET_PC(30)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst1_n),
        .mem_addr (addr1),
        .mem_req  (req1),
        .mem_rw   (rw1),
        .mem_wdata(wdata1),
        .mem_rdata(rdata1),
        .mem_wait (wait1),
        .pc       (pc1),
        .ac       (ac1),
        .halted   (halted1)
    );

    // ---------------- helpers ----------------
    int base_rise, base_wr, base_stall, base_viol;

    task automatic clear_mem0();
        for (int i = 0; i < 4096; i++) mem0[i] = '0;
    endtask

    task automatic start0(input int w);
        nwait = w;
        @(negedge clk);
        rst0_n = 1'b0;
        @(negedge clk);
        base_rise  = rise_n;
        base_wr    = wr_count;
        base_stall = stalls;
        base_viol  = viol;
        rst0_n = 1'b1;
    endtask

    task automatic wait_halt0(input string tag, input int budget);
        int i = 0;
        while (!halted0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, {31'd0, halted0}, 32'd1);
    endtask

    int          lat;
    logic [11:0] pc_s;
    logic [15:0] ac_s;
    logic [11:0] addr_s;
    int          rn_s;

    initial begin
        clear_mem0();
        for (int i = 0; i < 32; i++) mem1[i] = '0;

        // Asynchronous reset: both instances, no clock edge in between.
        #1;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        #1;
        check("rst_pc",     {20'd0, pc0},    32'h000);
        check("rst_ac",     {16'd0, ac0},    32'h0000);
        check("rst_req",    {31'd0, req0},   32'd0);
        check("rst_rw",     {31'd0, rw0},    32'd1);
        check("rst_halted", {31'd0, halted0}, 32'd0);
        check("rst_addr",   {20'd0, addr0},  32'h000);
        check("rst_wdata",  {16'd0, wdata0}, 32'h0000);
        check("rst1_pc",    {27'd0, pc1},    32'h1E);
        check("rst1_ac",    {24'd0, ac1},    32'h00);
        rst0_n = 1'b1;

        // LOAD 0x010, ADD 0x011, STORE 0x012, HALT; no wait states.
        clear_mem0();
        mem0[12'h000] = 16'h0010;
        mem0[12'h002] = 16'h4011;
        mem0[12'h004] = 16'h2012;
        mem0[12'h006] = 16'hE000;
        mem0[12'h010] = 16'h0005;
        mem0[12'h011] = 16'h0007;
        start0(0);
        wait_halt0("prog1_halt", 200);
        check("prog1_ac",      {16'd0, ac0},     32'h000C);
        check("prog1_pc",      {20'd0, pc0},     32'h008);
        check("prog1_writes",  wr_count - base_wr, 32'd1);
        check("prog1_wr_addr", {20'd0, wr_addr}, 32'h012);
        check("prog1_wr_data", {16'd0, wr_data}, 32'h000C);
        check("prog1_rises",   rise_n - base_rise, 32'd7);
        check("prog1_st_rw",   {31'd0, rise_rw[base_rise+5]}, 32'd0);
        check("lat_load",  rise_cyc[base_rise+2] - rise_cyc[base_rise+0], 32'd6);
        check("lat_add",   rise_cyc[base_rise+4] - rise_cyc[base_rise+2], 32'd6);
        check("lat_store", rise_cyc[base_rise+6] - rise_cyc[base_rise+4], 32'd5);

        // Halted core with mem_wait toggling: no request, no state change.
        pc_s   = pc0;
        ac_s   = ac0;
        addr_s = addr0;
        rn_s   = rise_n;
        wovr   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wovr_val = ~wovr_val;
            check("halt_req", {31'd0, req0}, 32'd0);
        end
        @(negedge clk);
        wovr = 1'b0;
        check("halt_pc",     {20'd0, pc0},   {20'd0, pc_s});
        check("halt_ac",     {16'd0, ac0},   {16'd0, ac_s});
        check("halt_addr",   {20'd0, addr0}, {20'd0, addr_s});
        check("halt_stay",   {31'd0, halted0}, 32'd1);
        check("halt_nofetch", rise_n - rn_s, 32'd0);

        // SUB 1 from 0 wraps to 0xFFFF; JNEG then taken.
        clear_mem0();
        mem0[12'h000] = 16'h6030;
        mem0[12'h002] = 16'hC020;
        mem0[12'h020] = 16'hE000;
        mem0[12'h030] = 16'h0001;
        start0(0);
        wait_halt0("prog2_halt", 200);
        check("sub_wrap_ac",  {16'd0, ac0}, 32'hFFFF);
        check("jneg_target",  {20'd0, rise_addr[base_rise+3]}, 32'h020);
        check("prog2_pc",     {20'd0, pc0}, 32'h022);
        check("lat_sub",  rise_cyc[base_rise+2] - rise_cyc[base_rise+0], 32'd6);
        check("lat_jneg", rise_cyc[base_rise+3] - rise_cyc[base_rise+2], 32'd3);

        // JNEG not taken on positive AC, then JMP.
        clear_mem0();
        mem0[12'h000] = 16'h0010;
        mem0[12'h002] = 16'hC020;
        mem0[12'h004] = 16'hA040;
        mem0[12'h010] = 16'h7FFF;
        mem0[12'h020] = 16'hE000;
        mem0[12'h040] = 16'hE000;
        start0(0);
        wait_halt0("prog3_halt", 200);
        check("jneg_fallthru", {20'd0, rise_addr[base_rise+3]}, 32'h004);
        check("jmp_target",    {20'd0, rise_addr[base_rise+4]}, 32'h040);
        check("prog3_pc",      {20'd0, pc0}, 32'h042);
        check("prog3_ac",      {16'd0, ac0}, 32'h7FFF);

        // Three stall cycles on every transaction; ADD has two transactions -> 6 + 2*3.
        clear_mem0();
        mem0[12'h000] = 16'h0010;
        mem0[12'h002] = 16'h4011;
        mem0[12'h004] = 16'h2012;
        mem0[12'h006] = 16'hE000;
        mem0[12'h010] = 16'h0005;
        mem0[12'h011] = 16'h0007;
        start0(3);
        wait_halt0("prog4_halt", 400);
        check("wait_lat_add", rise_cyc[base_rise+4] - rise_cyc[base_rise+2], 32'd12);
        check("wait_stalls",  stalls - base_stall, 32'd21);
        check("wait_stable",  viol - base_viol, 32'd0);
        check("wait_wr_data", {16'd0, wr_data}, 32'h000C);
        check("wait_ac",      {16'd0, ac0}, 32'h000C);

        // Reset pulse while a STORE is stalled in its memory phase.
        clear_mem0();
        mem0[12'h000] = 16'h2012;
        mem0[12'h002] = 16'hE000;
        start0(3);
        begin
            int i = 0;
            while ((rise_n - base_rise) < 2 && i < 40) begin
                @(negedge clk);
                i++;
            end
        end
        check("st_seen", rise_n - base_rise, 32'd2);
        check("st_in_wait", {30'd0, req0, rw0}, 32'b10);
        #2;
        rst0_n = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, req0}, 32'd0);
        check("rst_mid_pc",  {20'd0, pc0},  32'h000);
        check("rst_mid_rw",  {31'd0, rw0},  32'd1);
        @(negedge clk);
        check("rst_mid_nowr", wr_count - base_wr, 32'd0);
        rst0_n = 1'b1;
        @(negedge clk);
        check("rst_refetch_req",  {31'd0, req0}, 32'd1);
        check("rst_refetch_addr", {20'd0, addr0}, 32'h000);
        check("rst_refetch_rw",   {31'd0, rw0}, 32'd1);
        wait_halt0("prog5_halt", 400);
        check("prog5_writes", wr_count - base_wr, 32'd1);

        // 8-bit instance: LOAD at 0x1E, AND at 0x1F, PC wraps, HALT at 0x00.
        mem1[5'h1E] = 8'h10;
        mem1[5'h1F] = 8'h91;
        mem1[5'h00] = 8'hE0;
        mem1[5'h10] = 8'hB6;
        mem1[5'h11] = 8'h5C;
        @(negedge clk);
        rst1_n = 1'b1;
        begin
            int i = 0;
            while (!halted1 && i < 100) begin
                @(negedge clk);
                i++;
            end
        end
        check("w8_halt",     {31'd0, halted1}, 32'd1);
        check("w8_and_ac",   {24'd0, ac1}, 32'h14);
        check("w8_and_addr", {27'd0, rise1_addr[2]}, 32'h1F);
        check("w8_wrap_addr", {27'd0, rise1_addr[4]}, 32'h00);
        check("w8_pc",       {27'd0, pc1}, 32'h01);
        check("w8_lat_and",  rise1_cyc[4] - rise1_cyc[2], 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
